// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg
//   Shared constants for the time-of-day set/run controller: FSM state
//   encodings, field codes, field limits, display blank masks and small
//   decode helpers used by the controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_t;

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;

  localparam logic [5:0] MAX_SEC_MIN = 6'd59;
  localparam logic [4:0] MAX_HOUR    = 5'd23;

  // Digit order {hr10,hr1,min10,min1,sec10,sec1}
  localparam logic [5:0] BLANK_SEC  = 6'b000011;
  localparam logic [5:0] BLANK_MIN  = 6'b001100;
  localparam logic [5:0] BLANK_HOUR = 6'b110000;

  // Selected-field code shown on o_pos; RUN reports the seconds code (0).
  function automatic logic [1:0] state_to_pos(input state_t s);
    case (s)
      SET_MIN:  return POS_MIN;
      SET_HOUR: return POS_HOUR;
      default:  return POS_SEC;
    endcase
  endfunction

  // Blank mask of the field being edited; nothing blanks in RUN.
  function automatic logic [5:0] state_to_mask(input state_t s);
    case (s)
      SET_SEC:  return BLANK_SEC;
      SET_MIN:  return BLANK_MIN;
      SET_HOUR: return BLANK_HOUR;
      default:  return 6'b000000;
    endcase
  endfunction

endpackage

// File: rtl/mod_n_prescaler.sv
// mod_n_prescaler
//   Modulo-N cycle counter with enable and synchronous clear.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     i_en       : advance the count this cycle
//     i_clr      : synchronous clear to 0 (wins over i_en)
//     o_tc       : terminal count, high while enabled at count N-1
module mod_n_prescaler #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int W = (N > 2) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_reg;

  assign o_tc = i_en && !i_clr && (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (i_clr) begin
      cnt_reg <= '0;
    end else if (i_en) begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Owns the hh:mm:ss registers: advances them once per second in RUN and
//   lets the user edit one field at a time in SET, blinking the edited
//   field's two digits.
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     i_btn_mode         : pulse, toggle RUN/SET (highest priority)
//     i_btn_pos          : pulse, next field in SET
//     i_btn_inc          : pulse, increment selected field in SET
//     o_sec/o_min/o_hour : current time
//     o_mode, o_pos      : registered state decode (SET flag, field code)
//     o_blank            : per-digit blank mask, 1 = blank
//     o_tick             : one-cycle pulse on each RUN second advance
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int SEC_TICK_DIV = 50000000,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_mode,
  input  logic       i_btn_pos,
  input  logic       i_btn_inc,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic       o_mode,
  output logic [1:0] o_pos,
  output logic [5:0] o_blank,
  output logic       o_tick
);

  state_t     state_reg, state_next;
  logic [5:0] sec_reg, min_reg;
  logic [4:0] hour_reg;
  logic       mode_reg;
  logic [1:0] pos_reg;
  logic [5:0] blank_reg;
  logic       phase_reg, phase_next;   // 1 = blank half-period

  logic in_set, act_pos, act_inc;
  logic sec_en, sec_tc, blink_en, blink_tc;

  // Priority mode > pos > inc; pos/inc only act in SET.
  assign in_set  = (state_reg != RUN);
  assign act_pos = in_set && !i_btn_mode && i_btn_pos;
  assign act_inc = in_set && !i_btn_mode && !i_btn_pos && i_btn_inc;

  // Second prescaler runs only in RUN. A mode pulse clears it so that it
  // sits at 0 throughout SET and restarts from 0 on return to RUN.
  assign sec_en = !in_set && !i_btn_mode;

  // Blink prescaler runs only in SET; any acted-on pulse restarts it so
  // the edited value is visible immediately.
  assign blink_en = in_set && !i_btn_mode && !act_pos && !act_inc;

  mod_n_prescaler #(.N(SEC_TICK_DIV)) u_sec_div (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (sec_en),
    .i_clr (!sec_en),
    .o_tc  (sec_tc)
  );

  mod_n_prescaler #(.N(BLINK_DIV)) u_blink_div (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (blink_en),
    .i_clr (!blink_en),
    .o_tc  (blink_tc)
  );

  always_comb begin
    state_next = state_reg;
    if (i_btn_mode) begin
      state_next = in_set ? RUN : SET_SEC;
    end else if (act_pos) begin
      case (state_reg)
        SET_SEC: state_next = SET_MIN;
        SET_MIN: state_next = SET_HOUR;
        default: state_next = SET_SEC;
      endcase
    end
  end

  always_comb begin
    phase_next = phase_reg;
    if (!blink_en) begin
      phase_next = 1'b0;
    end else if (blink_tc) begin
      phase_next = ~phase_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      mode_reg  <= 1'b0;
      pos_reg   <= POS_SEC;
      phase_reg <= 1'b0;
      blank_reg <= '0;
      sec_reg   <= '0;
      min_reg   <= '0;
      hour_reg  <= '0;
    end else begin
      state_reg <= state_next;
      mode_reg  <= (state_next != RUN);
      pos_reg   <= state_to_pos(state_next);
      phase_reg <= phase_next;
      // Mask is zero for RUN, so no separate mode gating is needed here.
      blank_reg <= phase_next ? state_to_mask(state_next) : 6'b000000;

      if (sec_tc) begin
        if (sec_reg == MAX_SEC_MIN) begin
          sec_reg <= '0;
          if (min_reg == MAX_SEC_MIN) begin
            min_reg  <= '0;
            hour_reg <= (hour_reg == MAX_HOUR) ? 5'd0 : hour_reg + 5'd1;
          end else begin
            min_reg <= min_reg + 6'd1;
          end
        end else begin
          sec_reg <= sec_reg + 6'd1;
        end
      end else if (act_inc) begin
        // Edits wrap within the field; no carry into neighbours.
        case (state_reg)
          SET_SEC:  sec_reg  <= (sec_reg == MAX_SEC_MIN) ? 6'd0 : sec_reg + 6'd1;
          SET_MIN:  min_reg  <= (min_reg == MAX_SEC_MIN) ? 6'd0 : min_reg + 6'd1;
          SET_HOUR: hour_reg <= (hour_reg == MAX_HOUR) ? 5'd0 : hour_reg + 5'd1;
          default:  ;
        endcase
      end
    end
  end

  assign o_sec   = sec_reg;
  assign o_min   = min_reg;
  assign o_hour  = hour_reg;
  assign o_mode  = mode_reg;
  assign o_pos   = pos_reg;
  assign o_blank = blank_reg;
  assign o_tick  = sec_tc;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl
//   Self-checking bench: directed scenarios plus randomized button pulses,
//   all compared cycle by cycle against a seconds-of-day reference model.
module tb_clock_set_ctrl;

  localparam int SD = 4;
  localparam int BD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_pos = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       mode;
  logic [1:0] pos;
  logic [5:0] blank;
  logic       tick;

  clock_set_ctrl #(.SEC_TICK_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn_mode (btn_mode),
    .i_btn_pos  (btn_pos),
    .i_btn_inc  (btn_inc),
    .o_sec      (sec),
    .o_min      (min),
    .o_hour     (hour),
    .o_mode     (mode),
    .o_pos      (pos),
    .o_blank    (blank),
    .o_tick     (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time as seconds of day, field -1 = RUN else 0/1/2,
  // cycle counts since the last prescaler restart, blink phase (1 = blank).
  int m_t;
  int m_field;
  int m_run_cyc;
  int m_blink_cyc;
  bit m_phase;
  int tick_count;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int exp_blank();
    if (m_field < 0 || !m_phase) return 0;
    case (m_field)
      0:       return 6'b000011;
      1:       return 6'b001100;
      default: return 6'b110000;
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0; m_field = -1; m_run_cyc = 0; m_blink_cyc = 0; m_phase = 0;
  endtask

  task automatic check_regs();
    check("sec",   sec,   m_t % 60);
    check("min",   min,   (m_t / 60) % 60);
    check("hour",  hour,  m_t / 3600);
    check("mode",  mode,  (m_field >= 0) ? 1 : 0);
    check("pos",   pos,   (m_field >= 0) ? m_field : 0);
    check("blank", blank, exp_blank());
  endtask

  // One clock cycle with the given pulses; called and returns at negedge.
  task automatic step(input bit m, input bit p, input bit i);
    bit exp_tick;
    int s, mi, h;
    btn_mode = m; btn_pos = p; btn_inc = i;
    #1;
    exp_tick = (m_field < 0) && !m && (m_run_cyc == SD - 1);
    check("tick", tick, exp_tick);
    if (tick) tick_count++;
    if (m) begin
      m_field = (m_field < 0) ? 0 : -1;
      m_run_cyc = 0; m_blink_cyc = 0; m_phase = 0;
    end else if (m_field < 0) begin
      if (exp_tick) begin
        m_t = (m_t + 1) % 86400;
        m_run_cyc = 0;
      end else begin
        m_run_cyc++;
      end
    end else if (p) begin
      m_field = (m_field + 1) % 3;
      m_blink_cyc = 0; m_phase = 0;
    end else if (i) begin
      s = m_t % 60; mi = (m_t / 60) % 60; h = m_t / 3600;
      case (m_field)
        0:       s  = (s + 1) % 60;
        1:       mi = (mi + 1) % 60;
        default: h  = (h + 1) % 24;
      endcase
      m_t = h * 3600 + mi * 60 + s;
      m_blink_cyc = 0; m_phase = 0;
    end else begin
      m_blink_cyc++;
      if (m_blink_cyc == BD) begin
        m_blink_cyc = 0;
        m_phase = ~m_phase;
      end
    end
    @(posedge clk);
    @(negedge clk);
    btn_mode = 0; btn_pos = 0; btn_inc = 0;
    check_regs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    model_reset();
    check_regs();
    check("rst_tick", tick, 0);
    rst_n = 1;
  endtask

  initial begin
    tick_count = 0;
    model_reset();

    // Reset values and first second
    do_reset();
    $display("reset released");
    idle(4);
    check("sec_after_4", sec, 1);
    idle(236);
    check("sec_after_240", sec, 0);
    check("min_after_240", min, 1);
    check("ticks_240", tick_count, 60);
    $display("run 240 cycles: %02d:%02d:%02d ticks=%0d", hour, min, sec, tick_count);

    // Set 23:59:59 then wrap to midnight
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    incs(23);
    step(0, 1, 0); step(0, 1, 0);
    incs(59);
    step(0, 1, 0); step(0, 1, 0);
    incs(59);
    tick_count = 0;
    idle(20);
    check("no_tick_in_set", tick_count, 0);
    step(1, 0, 0);
    check("held_hour", hour, 23);
    check("held_min", min, 59);
    check("held_sec", sec, 59);
    idle(3);
    btn_mode = 0;
    #1;
    check("tick_4th_cycle", tick, 1);
    idle(1);
    check("wrap_hour", hour, 0);
    check("wrap_min", min, 0);
    check("wrap_sec", sec, 0);
    $display("set 23:59:59 and wrap: %02d:%02d:%02d", hour, min, sec);

    // SET_SEC wrap without carry
    step(1, 0, 0);
    incs(59);
    check("sec_59", sec, 59);
    step(0, 0, 1);
    check("sec_wrap_set", sec, 0);
    check("min_no_carry", min, 0);
    $display("set-sec wrap: %02d:%02d:%02d", hour, min, sec);

    // Blink in SET_MIN
    step(0, 1, 0);
    idle(3);
    check("blink_on_3", blank, 6'b001100);
    idle(3);
    check("blink_off_6", blank, 0);
    idle(3);
    check("blink_on_9", blank, 6'b001100);
    step(0, 0, 1);
    check("blink_inc_clear", blank, 0);
    idle(3);
    check("blink_restart", blank, 6'b001100);
    $display("blink sequence in SET_MIN done");

    // Simultaneous pulses in SET_SEC: mode wins
    step(0, 1, 0); step(0, 1, 0);
    check("in_set_sec", pos, 0);
    step(1, 1, 1);
    check("prio_mode", mode, 0);
    check("prio_pos", pos, 0);
    check("prio_blank", blank, 0);
    $display("mode+pos+inc priority done");

    // Async reset mid-cycle in SET_HOUR with hour=5
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    incs(5);
    check("hour_5", hour, 5);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_sec", sec, 0);
    check("arst_min", min, 0);
    check("arst_hour", hour, 0);
    check("arst_mode", mode, 0);
    check("arst_pos", pos, 0);
    check("arst_blank", blank, 0);
    check("arst_tick", tick, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    check_regs();
    idle(4);
    $display("async reset mid-cycle done");

    // Randomized pulses against the model
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) == 0);
    end
    $display("random run done: %02d:%02d:%02d", hour, min, sec);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Controller for a time-of-day display datapath. It owns the hh:mm:ss registers and advances them once per second in RUN mode. It also sequences a button-driven SET mode, with field select and increment, and drives a per-digit blink mask for the six-digit multiplexed display. It sits between the debounced push-button logic and the digit-split/segment-decode/display-mux path. Everything runs in the clk domain; no derived clocks.

Parameters:
SEC_TICK_DIV, 50000000, clk cycles per second tick (must be >=2)
BLINK_DIV, 25000000, clk cycles per blink half-period in SET mode (must be >=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
i_btn_mode  input  1  debounced single-cycle pulse: toggle RUN/SET
i_btn_pos  input  1  debounced single-cycle pulse: next field in SET
i_btn_inc  input  1  debounced single-cycle pulse: increment selected field in SET
o_sec  output  6  seconds 0..59
o_min  output  6  minutes 0..59
o_hour  output  5  hours 0..23
o_mode  output  1  0=RUN, 1=SET
o_pos  output  2  selected field: 0=sec, 1=min, 2=hour; 0 in RUN
o_blank  output  6  digit blank mask {hr10,hr1,min10,min1,sec10,sec1}, 1=blank
o_tick  output  1  one-cycle pulse on each RUN second advance

Behaviour:
- Reset: clk and rst_n are as stated above; reset is asynchronous, active-low.
- Reset values: o_sec=0, o_min=0, o_hour=0, o_mode=0, o_pos=0, o_blank=0, o_tick=0, state RUN, both prescalers 0, blink phase visible.
- Assertion mid-operation clears everything immediately.
- FSM states: RUN, SET_SEC, SET_MIN, SET_HOUR.
  - RUN --mode--> SET_SEC.
  - SET_x --mode--> RUN.
  - SET_SEC --pos--> SET_MIN --pos--> SET_HOUR --pos--> SET_SEC.
  - pos and inc are ignored in RUN.
- Pulse priority within one cycle: mode > pos > inc. Only the highest-priority pulse acts; the others are dropped.
- Second prescaler:
  - Counts 0..SEC_TICK_DIV-1 in RUN only.
  - o_tick=1 combinationally in the cycle where the count equals SEC_TICK_DIV-1. The time registers update on that same edge, and the count wraps to 0.
  - Held at 0 in all SET states.
  - On a SET->RUN transition, the count restarts at 0. The first tick is therefore SEC_TICK_DIV cycles after the mode pulse edge.
- RUN advance:
  - sec+1.
  - sec=59 -> sec=0, min+1.
  - min=59 with sec=59 -> min=0, hour+1.
  - 23:59:59 -> 00:00:00.
- SET increment (applies to the selected field only; no carry into other fields):
  - SET_SEC: sec 59 -> 0.
  - SET_MIN: min 59 -> 0.
  - SET_HOUR: hour 23 -> 0.
  - Takes effect on the pulse edge (1-cycle latency).
- Blink:
  - Blink prescaler free-runs only in SET. It toggles the blink phase every BLINK_DIV cycles.
  - In RUN it is held at 0 with phase visible.
  - A pos or inc pulse (when acted on) clears the prescaler and forces phase visible, so the edited value shows at once.
- o_blank:
  - Two bits of the selected field are 1 while phase = blank.
  - sec -> 6'b000011, min -> 6'b001100, hour -> 6'b110000.
  - 0 otherwise, and always 0 in RUN.
- Registers:
  - o_mode/o_pos are registered decodes of the state.
  - o_blank is registered from phase and state; it changes on the same edge as the phase toggle.
- Entering SET always selects sec (o_pos=0).
- Time values are preserved across mode changes.

Decomposition:
- Shared constants file (clock_ctrl_pkg):
  - state encodings RUN=2'd0, SET_SEC=2'd1, SET_MIN=2'd2, SET_HOUR=2'd3
  - field codes POS_SEC/POS_MIN/POS_HOUR
  - MAX_SEC_MIN=59, MAX_HOUR=23
  - blank masks for each field.
- One sub-module: mod_n_prescaler. It has parameter N, inputs i_en and i_clr (sync clear, priority over i_en), and output o_tc (count==N-1 while enabled). It is instantiated twice: second tick and blink.

Test Plan:
(All with SEC_TICK_DIV=4, BLINK_DIV=3.)
- Release reset, run 4 cycles -> o_tick one pulse, o_sec=1. After 240 cycles total -> o_sec=0, o_min=1, 60 o_tick pulses.
- mode pulse; inc x23 in SET_HOUR, x59 in SET_MIN, x59 in SET_SEC; mode pulse -> 23:59:59 held with no ticks in SET. 4 cycles after returning to RUN -> 00:00:00 with o_tick=1.
- In SET_SEC with sec=59, inc pulse -> sec=0, min unchanged. o_tick stays 0 for 20 cycles in SET.
- pos pulse into SET_MIN, then idle -> o_blank=6'b001100 after 3 cycles, 0 after 6, 001100 after 9. An inc pulse at a blank point -> o_blank=0 next cycle, and the blink restarts from 0.
- In SET_SEC, mode+inc+pos in the same cycle -> state RUN, o_mode=0, o_sec unchanged, o_pos=0, o_blank=0.
- In SET_HOUR with hour=5, assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, state RUN after release.
